// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Fetch-stage bus: instruction memory port, decode handshake,
//            branch redirect and halt status.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd_en;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              halted;

    modport master (
        output imem_addr,
        output imem_rd_en,
        input  imem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  branch_taken,
        input  branch_target,
        output halted
    );

    modport slave (
        input  imem_addr,
        input  imem_rd_en,
        output imem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output branch_taken,
        output branch_target,
        input  halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC, synchronous imem reads, output + skid register toward
//            decode, branch redirect and HALT stop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    localparam logic [5:0]        c_OP_HALT  = 6'b111111;
    localparam logic [0:0]        c_ST_RUN   = 1'b0;
    localparam logic [0:0]        c_ST_HALT  = 1'b1;
    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic [31:0]       r_skid;
    logic [ADDR_W-1:0] r_skid_pc;
    logic              r_skid_valid;
    logic              r_halted;

    logic w_run;
    logic w_rd_en;
    logic w_redirect;
    logic w_resp;
    logic w_out_free;
    logic w_resp_kept;
    logic w_replay;
    logic w_resp_halt;

    always_comb begin
        w_run       = (r_state == c_ST_RUN);
        w_rd_en     = rst_n && w_run && !r_skid_valid;
        w_redirect  = w_run && bus.branch_taken;
        w_resp      = r_inflight && !w_redirect;
        w_out_free  = !r_instr_valid || bus.instr_ready;
        w_resp_kept = w_resp && (w_out_free || !r_skid_valid);
        // The word issued in the cycle the skid filled has nowhere to land
        // if decode is still stalled; it is dropped and fetched again.
        w_replay    = w_resp && !w_out_free && r_skid_valid;
        w_resp_halt = w_resp_kept && (bus.imem_rdata[31:26] == c_OP_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_RUN;
            r_pc          <= c_RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_skid        <= '0;
            r_skid_pc     <= '0;
            r_skid_valid  <= 1'b0;
            r_halted      <= 1'b0;
        end else if (w_redirect) begin
            r_pc          <= bus.branch_target;
            r_inflight    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_skid_valid  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en && !w_resp_halt;
            if (w_rd_en) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + ADDR_W'(1);
            end
            if (w_replay) begin
                r_pc <= r_inflight_pc;
            end

            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_instr       <= r_skid;
                    r_instr_pc    <= r_skid_pc;
                    r_instr_valid <= 1'b1;
                    r_skid_valid  <= w_resp;
                    if (w_resp) begin
                        r_skid    <= bus.imem_rdata;
                        r_skid_pc <= r_inflight_pc;
                    end
                end else if (w_resp) begin
                    r_instr       <= bus.imem_rdata;
                    r_instr_pc    <= r_inflight_pc;
                    r_instr_valid <= 1'b1;
                end else begin
                    r_instr_valid <= 1'b0;
                end
            end else if (w_resp && !r_skid_valid) begin
                r_skid       <= bus.imem_rdata;
                r_skid_pc    <= r_inflight_pc;
                r_skid_valid <= 1'b1;
            end

            if (w_resp_halt) begin
                r_state  <= c_ST_HALT;
                r_halted <= 1'b1;
            end
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.imem_rd_en  = w_rd_en;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed + random bench for fetch_unit with a stream-level
//            reference model (expected next PC, halt seen).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    logic rst4_n;

    fetch_unit_if #(.ADDR_W(10)) bus  ();
    fetch_unit_if #(.ADDR_W(4))  bus4 ();

    fetch_unit #(.ADDR_W(10), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_unit #(.ADDR_W(4), .RESET_PC(14)) dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (bus4)
    );

    logic [31:0] mem  [0:1023];
    logic [31:0] mem4 [0:15];

    int n_checks = 0;
    int n_fail   = 0;
    int n_deliv  = 0;
    logic [9:0] exp_pc = '0;
    logic       model_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.imem_rd_en)  bus.imem_rdata  <= mem[bus.imem_addr];
    always @(posedge clk) if (bus4.imem_rd_en) bus4.imem_rdata <= mem4[bus4.imem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: applies inputs for the next rising edge and
    // scores any transfer that edge will perform.
    task automatic drive_cycle(input logic rdy, input logic br, input logic [9:0] tgt);
        if (model_done) begin
            check("post_halt_valid", 32'(bus.instr_valid), 32'd0);
            check("post_halt_rd_en", 32'(bus.imem_rd_en), 32'd0);
        end
        bus.instr_ready   = rdy;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        if (bus.instr_valid && rdy) begin
            check("xfer_pc", 32'(bus.instr_pc), 32'(exp_pc));
            check("xfer_instr", bus.instr, mem[exp_pc]);
            if (mem[exp_pc][31:26] == 6'h3F) begin
                check("halted_with_halt_word", 32'(bus.halted), 32'd1);
                model_done = 1'b1;
            end
            exp_pc = exp_pc + 10'd1;
            n_deliv++;
        end
        if (br && !model_done) exp_pc = tgt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.instr_ready  = 1'b1;
        bus.branch_taken = 1'b0;
        @(negedge clk);
        check("rst_valid",  32'(bus.instr_valid), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_rd_en",  32'(bus.imem_rd_en), 32'd0);
        check("rst_instr",  bus.instr, 32'd0);
        check("rst_pc",     32'(bus.instr_pc), 32'd0);
        check("rst_addr",   32'(bus.imem_addr), 32'd0);
        rst_n = 1'b1;
        model_done = 1'b0;
        exp_pc = '0;
        #1;
        check("rel_rd_en", 32'(bus.imem_rd_en), 32'd1);
        check("rel_addr",  32'(bus.imem_addr), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.instr_valid && n < 6) begin
            drive_cycle(1'b1, 1'b0, '0);
            n++;
        end
        check(tag, 32'(bus.instr_valid), 32'd1);
    endtask

    task automatic run_to_pc(input logic [9:0] pc, input string tag);
        int n = 0;
        while (!(bus.instr_valid && bus.instr_pc == pc) && n < 40) begin
            drive_cycle(1'b1, 1'b0, '0);
            n++;
        end
        check(tag, 32'(bus.instr_pc), 32'(pc));
    endtask

    initial begin
        int base;
        int got;
        logic       rdy;
        logic       br;
        logic [9:0] tgt;
        logic [3:0] e4;

        rst_n  = 1'b0;
        rst4_n = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = '0;
        bus4.instr_ready   = 1'b1;
        bus4.branch_taken  = 1'b0;
        bus4.branch_target = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'(i);
        for (int i = 0; i < 16; i++)   mem4[i] = 32'h200 + 32'(i);

        // Reset release and first-fetch latency
        do_reset();
        @(negedge clk);
        check("first_cycle_valid", 32'(bus.instr_valid), 32'd0);
        drive_cycle(1'b1, 1'b0, '0);
        check("first_valid", 32'(bus.instr_valid), 32'd1);
        check("first_pc", 32'(bus.instr_pc), 32'd0);

        // Decode stall of three cycles at pc 4
        run_to_pc(10'd4, "reach_pc4");
        for (int i = 0; i < 3; i++) begin
            check("stall_instr", bus.instr, 32'h104);
            check("stall_rd_en", 32'(bus.imem_rd_en), (i == 0) ? 32'd1 : 32'd0);
            drive_cycle(1'b0, 1'b0, '0);
        end
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, '0);

        // Redirect while the next word is in flight
        run_to_pc(10'd16, "reach_pc16");
        drive_cycle(1'b1, 1'b1, 10'h20);
        check("redir_rd_en", 32'(bus.imem_rd_en), 32'd1);
        check("redir_addr",  32'(bus.imem_addr), 32'h20);
        wait_valid("redir_valid");
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, '0);

        // Reset while stalled with skid full
        drive_cycle(1'b0, 1'b0, '0);
        drive_cycle(1'b0, 1'b0, '0);
        do_reset();
        wait_valid("restart_valid");
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, '0);

        // HALT at address 3, branch ignored afterwards, reset restarts
        mem[3] = 32'hFC000000;
        do_reset();
        base = n_deliv;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, '0);
        check("halt_delivered", 32'(n_deliv - base), 32'd4);
        check("halt_sticky", 32'(bus.halted), 32'd1);
        drive_cycle(1'b1, 1'b1, 10'h20);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, '0);
        check("halt_after_branch", 32'(bus.halted), 32'd1);
        do_reset();
        wait_valid("post_halt_restart");
        check("restart_halted", 32'(bus.halted), 32'd0);
        drive_cycle(1'b1, 1'b0, '0);

        // Redirect coinciding with HALT word arrival: redirect wins
        do_reset();
        run_to_pc(10'd2, "reach_pc2");
        drive_cycle(1'b1, 1'b1, 10'h30);
        base = n_deliv;
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, '0);
        check("simul_halted", 32'(bus.halted), 32'd0);
        check("simul_progress", 32'(n_deliv - base > 2), 32'd1);

        // Random back-pressure and redirects over random non-HALT code
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:26] == 6'h3F) mem[i][31] = 1'b0;
        end
        do_reset();
        base = n_deliv;
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 19) == 0);
            tgt = 10'($urandom);
            drive_cycle(rdy, br, tgt);
        end
        check("random_progress", 32'(n_deliv - base >= 50), 32'd1);
        check("random_halted", 32'(bus.halted), 32'd0);

        // Narrow PC wraps from RESET_PC=14
        @(negedge clk);
        rst4_n = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus4.instr_valid && got < 4) begin
                e4 = 4'(14 + got);
                check("wrap_pc", 32'(bus4.instr_pc), 32'(e4));
                check("wrap_instr", bus4.instr, mem4[e4]);
                got++;
            end
        end
        check("wrap_count", 32'(got), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
